// File: rtl/mccpu_dataflow_if.sv
// Unified instruction/data memory port: req/ready handshake with arbitrary wait states.
interface mccpu_dataflow_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mccpu_dataflow.sv
// Multi-cycle MIPS-subset core: 5-state FSM sharing one memory port, instret counter, debug reg read.
// Optional signed-overflow trap on add/sub/addi enabled by defining OVF_TRAP_EN.
module mccpu_dataflow #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  mccpu_dataflow_if.master mem,
  output logic [31:0]      pc,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             exc,
  output logic [31:0]      epc,
  input  logic [4:0]       reg_addr,
  output logic [31:0]      reg_out
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           state_q, next_state;
  logic [31:0]      pc_q, pc_next, ir, a_q, b_q, alu_out, mdr;
  logic [CNT_W-1:0] instret_q;
  logic [31:0]      regs [32];
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] imm_s, imm_z, pc_plus4;
  logic        accept;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sa       = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_s    = {{16{ir[15]}}, ir[15:0]};
  assign imm_z    = {16'd0, ir[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = mem.mem_req & mem.mem_ready;

  logic [31:0] alu_res, jump_tgt;
  logic        ovf_c, is_alu, writes_rd, is_lw, is_sw, is_br, br_taken, is_jump, is_link;

  // Instruction decode and ALU, evaluated from the latched IR/A/B.
  always_comb begin
    alu_res   = 32'd0;
    jump_tgt  = 32'd0;
    ovf_c     = 1'b0;
    is_alu    = 1'b0;
    writes_rd = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_br     = 1'b0;
    br_taken  = 1'b0;
    is_jump   = 1'b0;
    is_link   = 1'b0;
    case (op)
      6'h00: begin
        is_alu    = 1'b1;
        writes_rd = 1'b1;
        case (funct)
          6'h20: begin
            alu_res = a_q + b_q;
            ovf_c   = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
          end
          6'h22: begin
            alu_res = a_q - b_q;
            ovf_c   = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
          end
          6'h24: alu_res = a_q & b_q;
          6'h25: alu_res = a_q | b_q;
          6'h26: alu_res = a_q ^ b_q;
          6'h00: alu_res = b_q << sa;
          6'h02: alu_res = b_q >> sa;
          6'h03: alu_res = 32'($signed(b_q) >>> sa);
          6'h08: begin
            is_alu    = 1'b0;
            writes_rd = 1'b0;
            is_jump   = 1'b1;
            jump_tgt  = a_q;
          end
          default: begin
            is_alu    = 1'b0;
            writes_rd = 1'b0;
          end
        endcase
      end
      6'h08: begin
        is_alu  = 1'b1;
        alu_res = a_q + imm_s;
        ovf_c   = (a_q[31] == imm_s[31]) && (alu_res[31] != a_q[31]);
      end
      6'h0C: begin is_alu = 1'b1; alu_res = a_q & imm_z; end
      6'h0D: begin is_alu = 1'b1; alu_res = a_q | imm_z; end
      6'h0E: begin is_alu = 1'b1; alu_res = a_q ^ imm_z; end
      6'h0F: begin is_alu = 1'b1; alu_res = {ir[15:0], 16'd0}; end
      6'h23: begin is_lw = 1'b1; alu_res = a_q + imm_s; end
      6'h2B: begin is_sw = 1'b1; alu_res = a_q + imm_s; end
      6'h04: begin is_br = 1'b1; br_taken = (a_q == b_q); end
      6'h05: begin is_br = 1'b1; br_taken = (a_q != b_q); end
      6'h02: begin is_jump = 1'b1; jump_tgt = {pc_plus4[31:28], ir[25:0], 2'b00}; end
      6'h03: begin
        is_jump  = 1'b1;
        is_link  = 1'b1;
        jump_tgt = {pc_plus4[31:28], ir[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  logic        retire, trap, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef OVF_TRAP_EN
  logic        ovf_q;
`endif

  // Next-state, pc update, retire and register-file write port.
  always_comb begin
    next_state = state_q;
    pc_next    = pc_q;
    retire     = 1'b0;
    trap       = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    case (state_q)
      S_FETCH:  if (accept) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        next_state = S_FETCH;
        pc_next    = pc_plus4;
        retire     = 1'b1;
        if (is_alu) begin
          next_state = S_WB;
          pc_next    = pc_q;
          retire     = 1'b0;
        end else if (is_lw || is_sw) begin
          next_state = S_MEM;
          pc_next    = pc_q;
          retire     = 1'b0;
        end else if (is_br) begin
          if (br_taken) pc_next = pc_plus4 + {imm_s[29:0], 2'b00};
        end else if (is_jump) begin
          pc_next = jump_tgt;
          if (is_link) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q + 32'd8;
          end
        end
      end
      S_MEM: begin
        if (accept) begin
          if (is_sw) begin
            next_state = S_FETCH;
            pc_next    = pc_plus4;
            retire     = 1'b1;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        pc_next    = pc_plus4;
        retire     = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = writes_rd ? rd : rt;
        rf_wdata   = is_lw ? mdr : alu_out;
`ifdef OVF_TRAP_EN
        if (ovf_q) begin
          rf_we   = 1'b0;
          retire  = 1'b0;
          trap    = 1'b1;
          pc_next = EXC_VECTOR;
        end
`endif
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Memory outputs are registered from the next state so the request is up in the FETCH/MEM cycle itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      ir        <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= RESET_PC;
      wdata_q   <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      state_q <= next_state;
      pc_q    <= pc_next;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_q == S_FETCH && accept) ir <= mem.mem_rdata;
      if (state_q == S_DECODE) begin
        a_q <= regs[rs];
        b_q <= regs[rt];
      end
      if (state_q == S_EXEC) alu_out <= alu_res;
      if (state_q == S_MEM && accept) mdr <= mem.mem_rdata;
      if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
      req_q   <= (next_state == S_FETCH) || (next_state == S_MEM);
      we_q    <= (next_state == S_MEM) && is_sw;
      addr_q  <= (next_state == S_MEM) ? ((state_q == S_EXEC) ? alu_res : alu_out) : pc_next;
      wdata_q <= b_q;
    end
  end

`ifdef OVF_TRAP_EN
  logic        exc_q;
  logic [31:0] epc_q;

  // Overflow is captured in EXEC and acted on in WB.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      exc_q <= 1'b0;
      epc_q <= 32'd0;
    end else begin
      if (state_q == S_EXEC) ovf_q <= ovf_c && is_alu;
      exc_q <= trap;
      if (trap) epc_q <= pc_q;
    end
  end

  assign exc = exc_q;
  assign epc = epc_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{EXC_VECTOR, ovf_c, trap};
  assign exc = 1'b0;
  assign epc = 32'd0;
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign pc            = pc_q;
  assign state         = 3'(state_q);
  assign instret       = instret_q;
  assign reg_out       = (reg_addr == 5'd0) ? 32'd0 : regs[reg_addr];

endmodule

// File: tb/tb_mccpu_dataflow.sv
// Directed bench for mccpu_dataflow with a wait-state memory responder and hand-computed expectations.
module tb_mccpu_dataflow;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  reg_addr = 5'd0;
  logic [31:0] pc, epc, reg_out, instret;
  logic [2:0]  state;
  logic        exc;

  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int cnt    = 0;
  int wr_cnt = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [31:0] mem_arr [256];

  mccpu_dataflow_if bus ();

  mccpu_dataflow #(.RESET_PC(32'h40), .EXC_VECTOR(32'h8), .CNT_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem      (bus),
    .pc       (pc),
    .state    (state),
    .instret  (instret),
    .exc      (exc),
    .epc      (epc),
    .reg_addr (reg_addr),
    .reg_out  (reg_out)
  );

  always #5 clock = ~clock;

  // Memory responder: wait_n wait states per access, completes on the edge where req&ready.
  initial begin : responder
    logic        hs_we;
    logic [31:0] hs_addr, hs_wdata;
    hs_we = 1'b0;
    hs_addr = 32'd0;
    hs_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    mem_arr[16]  = 32'h2001_0005; // 0x40 addi r1,r0,5
    mem_arr[17]  = 32'h2002_FFFD; // 0x44 addi r2,r0,-3
    mem_arr[18]  = 32'h0022_1820; // 0x48 add  r3,r1,r2
    mem_arr[19]  = 32'hAC03_0008; // 0x4C sw   r3,8(r0)
    mem_arr[20]  = 32'h8C04_0008; // 0x50 lw   r4,8(r0)
    mem_arr[21]  = 32'h1421_0005; // 0x54 bne  r1,r1,5
    mem_arr[22]  = 32'h0022_2822; // 0x58 sub  r5,r1,r2
    mem_arr[23]  = 32'h3406_FFFF; // 0x5C ori  r6,r0,0xFFFF
    mem_arr[24]  = 32'h3C07_8000; // 0x60 lui  r7,0x8000
    mem_arr[25]  = 32'h20E8_FFFF; // 0x64 addi r8,r7,-1
    mem_arr[26]  = 32'h200A_0001; // 0x68 addi r10,r0,1
    mem_arr[27]  = 32'h010A_4820; // 0x6C add  r9,r8,r10
    mem_arr[28]  = 32'h0007_5903; // 0x70 sra  r11,r7,4
    mem_arr[29]  = 32'h2000_0007; // 0x74 addi r0,r0,7
    mem_arr[30]  = 32'h0800_0040; // 0x78 j    0x100
    mem_arr[64]  = 32'h0C00_0080; // 0x100 jal 0x200
    mem_arr[128] = 32'h1021_FFFF; // 0x200 beq r1,r1,-1
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.mem_ready) begin
        if (!reset && hs_we) begin
          mem_arr[hs_addr[9:2]] = hs_wdata;
          wr_cnt++;
          last_waddr = hs_addr;
          last_wdata = hs_wdata;
        end
        cnt = 0;
      end
      if (reset) wr_cnt = 0;
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !reset) begin
        if (cnt >= wait_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];
          hs_we    = bus.mem_we;
          hs_addr  = bus.mem_addr;
          hs_wdata = bus.mem_wdata;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [4:0] idx, output logic [31:0] val);
    reg_addr = idx;
    #1;
    val = reg_out;
  endtask

  task automatic run_to(input logic [31:0] target, input int max, output int cyc);
    cyc = 0;
    while (instret !== target && cyc < max) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_req(input int max);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin : stim
    logic [31:0] v;
    int cyc;
    int found;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h40);
    check("rst_instret", instret, 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_epc", epc, 32'd0);
    rd_reg(5'd1, v);
    check("rst_r1", v, 32'd0);

    // Zero-wait ALU sequence
    reset = 1'b0;
    @(negedge clock);
    wait_req(5);
    check("fetch_req", 32'(bus.mem_req), 32'd1);
    check("fetch_addr", bus.mem_addr, 32'h40);
    check("fetch_we", 32'(bus.mem_we), 32'd0);
    run_to(32'd3, 100, cyc);
    check("alu3_cycles", 32'(cyc), 32'd12);
    check("alu3_instret", instret, 32'd3);
    check("alu3_pc", pc, 32'h4C);
    rd_reg(5'd1, v); check("r1", v, 32'd5);
    rd_reg(5'd2, v); check("r2", v, 32'hFFFF_FFFD);
    rd_reg(5'd3, v); check("r3", v, 32'd2);

    // Reset while a fetch is stalled
    @(negedge clock);
    wait_n = 10;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clock);
      if (state == 3'd0 && bus.mem_req && cnt >= 3) found = 1;
    end
    check("stall_seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_req", 32'(bus.mem_req), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_pc", pc, 32'h40);
    check("abort_instret", instret, 32'd0);
    rd_reg(5'd1, v); check("abort_r1", v, 32'd0);

    // Rerun with 2 wait states on every access
    wait_n = 2;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wait_req(5);
    run_to(32'd3, 200, cyc);
    check("ws_alu3_cycles", 32'(cyc), 32'd18);
    run_to(32'd4, 100, cyc);
    check("sw_cycles", 32'(cyc), 32'd8);
    check("sw_count", 32'(wr_cnt), 32'd1);
    check("sw_addr", last_waddr, 32'd8);
    check("sw_data", last_wdata, 32'd2);
    run_to(32'd5, 100, cyc);
    check("lw_cycles", 32'(cyc), 32'd9);
    rd_reg(5'd4, v); check("r4", v, 32'd2);
    run_to(32'd6, 100, cyc);
    check("bne_cycles", 32'(cyc), 32'd5);
    check("bne_pc", pc, 32'h58);

`ifdef OVF_TRAP_EN
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clock);
      if (exc) found = 1;
    end
    check("trap_seen", 32'(found), 32'd1);
    check("trap_epc", epc, 32'h6C);
    check("trap_pc", pc, 32'h8);
    check("trap_instret", instret, 32'd11);
    rd_reg(5'd9, v); check("trap_r9", v, 32'd0);
`else
    run_to(32'd13, 400, cyc);
    check("i13_instret", instret, 32'd13);
    rd_reg(5'd5,  v); check("r5_sub", v, 32'd8);
    rd_reg(5'd6,  v); check("r6_ori", v, 32'h0000_FFFF);
    rd_reg(5'd7,  v); check("r7_lui", v, 32'h8000_0000);
    rd_reg(5'd8,  v); check("r8_addi", v, 32'h7FFF_FFFF);
    rd_reg(5'd10, v); check("r10", v, 32'd1);
    rd_reg(5'd9,  v); check("r9_wrap", v, 32'h8000_0000);
    rd_reg(5'd11, v); check("r11_sra", v, 32'hF800_0000);
    run_to(32'd14, 100, cyc);
    rd_reg(5'd0, v); check("r0", v, 32'd0);
    check("i14_pc", pc, 32'h78);
    run_to(32'd15, 100, cyc);
    check("j_pc", pc, 32'h100);
    run_to(32'd16, 100, cyc);
    check("jal_pc", pc, 32'h200);
    rd_reg(5'd31, v); check("jal_r31", v, 32'h108);
    run_to(32'd17, 100, cyc);
    check("beq_cycles", 32'(cyc), 32'd5);
    check("beq_pc", pc, 32'h200);
    check("beq_instret", instret, 32'd17);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
